// File: rtl/eth_pkt_loopback.sv
// eth_pkt_loopback
// Store-and-forward AXI4-Stream packet loopback for one 10G MAC port.
// Whole frames are buffered in a simple dual-port RAM. A frame becomes
// visible to the transmit side only once its tlast beat has been
// written with tuser clear. Errored frames and frames that do not fit
// are rolled back and never retransmitted.
//
// Ports
//   clk156, eth_rst              core clock, synchronous active-high reset
//   s_axis_*                     MAC RX stream (no tready: every beat is taken)
//   m_axis_*                     MAC TX stream under tready backpressure
//   good_cnt / err_cnt / full_cnt  frame statistics (wrapping)
module eth_pkt_loopback #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk156,
    input  logic                  eth_rst,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [CNT_WIDTH-1:0]  good_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [CNT_WIDTH-1:0]  full_cnt
);

    localparam int MEM_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_WRITE = 1'b0,
        ST_DROP  = 1'b1
    } state_t;

    // {last, keep, data}
    logic [MEM_WIDTH-1:0]  r_mem [0:DEPTH-1];
    logic [MEM_WIDTH-1:0]  r_out;
    logic                  r_tvalid;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_wr_commit;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_next;
    logic [ADDR_WIDTH-1:0] w_commit_next;
    logic [CNT_WIDTH-1:0]  r_good_cnt;
    logic [CNT_WIDTH-1:0]  r_err_cnt;
    logic [CNT_WIDTH-1:0]  r_full_cnt;

    logic w_full;
    logic w_wr_en;
    logic w_rd_en;
    logic w_good_inc;
    logic w_err_inc;
    logic w_full_inc;

    // One slot is always left empty so that full and empty are distinct.
    // The registered read pointer is used, so a slot freed by a read in
    // this cycle only becomes usable next cycle.
    assign w_full = ((r_wr_ptr + 1'b1) == r_rd_ptr);

    // Only committed data is ever read, so a partial frame never leaves.
    assign w_rd_en = (r_rd_ptr != r_wr_commit) && (!r_tvalid || m_axis_tready);

    // ------------------------------------------------------------------
    // Write-side FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            r_state     <= ST_WRITE;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_good_cnt  <= '0;
            r_err_cnt   <= '0;
            r_full_cnt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wr_ptr    <= w_wr_ptr_next;
            r_wr_commit <= w_commit_next;
            if (w_good_inc) r_good_cnt <= r_good_cnt + 1'b1;
            if (w_err_inc)  r_err_cnt  <= r_err_cnt + 1'b1;
            if (w_full_inc) r_full_cnt <= r_full_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write-side FSM: next state and controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_wr_en       = 1'b0;
        w_wr_ptr_next = r_wr_ptr;
        w_commit_next = r_wr_commit;
        w_good_inc    = 1'b0;
        w_err_inc     = 1'b0;
        w_full_inc    = 1'b0;
        case (r_state)
            ST_WRITE: begin
                if (s_axis_tvalid) begin
                    if (s_axis_tlast && s_axis_tuser) begin
                        // Errored frame: roll back. Takes priority over the
                        // full case so such a frame is counted only once.
                        w_wr_ptr_next = r_wr_commit;
                        w_err_inc     = 1'b1;
                    end else if (w_full) begin
                        w_wr_ptr_next = r_wr_commit;
                        if (s_axis_tlast) begin
                            w_full_inc = 1'b1;
                        end else begin
                            w_state_next = ST_DROP;
                        end
                    end else begin
                        w_wr_en       = 1'b1;
                        w_wr_ptr_next = r_wr_ptr + 1'b1;
                        if (s_axis_tlast) begin
                            w_commit_next = r_wr_ptr + 1'b1;
                            w_good_inc    = 1'b1;
                        end
                    end
                end
            end
            ST_DROP: begin
                // Discard the rest of an overflowed frame; tuser is moot.
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_full_inc   = 1'b1;
                    w_state_next = ST_WRITE;
                end
            end
            default: w_state_next = ST_WRITE;
        endcase
    end

    // ------------------------------------------------------------------
    // Buffer RAM. Contents are not cleared by reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk156) begin
        if (w_wr_en && !eth_rst) begin
            r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // The output register doubles as the RAM's registered read port.
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            r_out <= '0;
        end else if (w_rd_en) begin
            r_out <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            r_rd_ptr <= '0;
            r_tvalid <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_out[MEM_WIDTH-1];
    assign m_axis_tkeep  = r_out[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis_tdata  = r_out[DATA_WIDTH-1:0];
    assign m_axis_tuser  = 1'b0;

    assign good_cnt = r_good_cnt;
    assign err_cnt  = r_err_cnt;
    assign full_cnt = r_full_cnt;

endmodule

// File: tb/tb_eth_pkt_loopback.sv
// Directed testbench for eth_pkt_loopback (small 16-entry buffer).
`timescale 1ns/1ps
module tb_eth_pkt_loopback;

    logic        clk156 = 1'b0;
    logic        eth_rst;
    logic        s_axis_tvalid;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [31:0] good_cnt;
    logic [31:0] err_cnt;
    logic [31:0] full_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [72:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [73:0] held_word;
    logic [63:0] rdy_pat = 64'hDB6D_B6DB_6DB6_DB6D;

    always #5 clk156 = ~clk156;

    eth_pkt_loopback #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(64),
        .CNT_WIDTH (32)
    ) dut (
        .clk156       (clk156),
        .eth_rst      (eth_rst),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .good_cnt     (good_cnt),
        .err_cnt      (err_cnt),
        .full_cnt     (full_cnt)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Inputs change 1 ns after the rising edge and are accepted at the next one.
    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k,
                              input logic l, input logic u);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        @(posedge clk156); #1;
    endtask

    task automatic idle_in();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [63:0] base,
                              input logic [7:0] last_keep, input logic user,
                              input bit expect_out);
        for (int i = 0; i < n; i++) begin
            logic       l;
            logic [7:0] k;
            l = (i == n - 1);
            k = l ? last_keep : 8'hFF;
            if (expect_out) exp_q.push_back({l, k, base + 64'(i)});
            drive_beat(base + 64'(i), k, l, l ? user : 1'b0);
        end
        idle_in();
    endtask

    task automatic do_reset();
        idle_in();
        eth_rst = 1'b1;
        exp_q.delete();
        repeat (2) begin @(posedge clk156); #1; end
        eth_rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk156); #1;
            c++;
        end
        chk(tag, exp_q.size(), 0);
        repeat (3) begin @(posedge clk156); #1; end
    endtask

    // Output monitor: scoreboard each accepted beat and check that a
    // stalled beat does not change before it is taken.
    always @(negedge clk156) begin
        if (eth_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, held_word);
            if (m_axis_tvalid && m_axis_tready) begin
                chk("tuser_zero", m_axis_tuser, 1'b0);
                if (exp_q.size() == 0) begin
                    int sz;
                    sz = exp_q.size();
                    chk("extra_beat_qsize", sz, 1);
                end else begin
                    chk("beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_q.pop_front());
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            held_word  = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        eth_rst       = 1'b1;
        m_axis_tready = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        idle_in();
        repeat (3) begin @(posedge clk156); #1; end
        eth_rst = 1'b0;

        // Reset state
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast",  m_axis_tlast, 1'b0);
        chk("rst_tuser",  m_axis_tuser, 1'b0);
        chk("rst_tdata",  m_axis_tdata, 64'h0);
        chk("rst_tkeep",  m_axis_tkeep, 8'h0);
        chk("rst_cnts",   {good_cnt, err_cnt, full_cnt}, 96'h0);

        // Good frame with 2-cycle latency from the tlast beat
        m_axis_tready = 1'b1;
        send_frame(8, 64'h1, 8'h0F, 1'b0, 1'b1);
        chk("lat_edge_n_tvalid", m_axis_tvalid, 1'b0);
        @(posedge clk156); #1;
        chk("lat_edge_n1_tvalid", m_axis_tvalid, 1'b1);
        chk("lat_edge_n1_tdata", m_axis_tdata, 64'h1);
        wait_drain("good_drain", 50);
        chk("good_good_cnt", good_cnt, 32'd1);

        // Errored frame followed by a good one
        do_reset();
        send_frame(5, 64'h11, 8'hFF, 1'b1, 1'b0);
        send_frame(3, 64'h21, 8'h03, 1'b0, 1'b1);
        wait_drain("err_drain", 50);
        chk("err_err_cnt",  err_cnt,  32'd1);
        chk("err_good_cnt", good_cnt, 32'd1);

        // Overflow: 20-beat frame cannot fit 15 beats, next 4-beat frame passes
        do_reset();
        m_axis_tready = 1'b0;
        send_frame(20, 64'h100, 8'hFF, 1'b0, 1'b0);
        chk("ovf_full_cnt_mid", full_cnt, 32'd1);
        send_frame(4, 64'h200, 8'h07, 1'b0, 1'b1);
        chk("ovf_good_cnt", good_cnt, 32'd1);
        chk("ovf_err_cnt",  err_cnt,  32'd0);
        m_axis_tready = 1'b1;
        wait_drain("ovf_drain", 50);
        chk("ovf_full_cnt", full_cnt, 32'd1);

        // Exact fill: 3 x 5 beats = full usable capacity
        do_reset();
        m_axis_tready = 1'b0;
        send_frame(5, 64'h300, 8'hFF, 1'b0, 1'b1);
        send_frame(5, 64'h310, 8'h1F, 1'b0, 1'b1);
        send_frame(5, 64'h320, 8'h01, 1'b0, 1'b1);
        chk("fill_good_cnt", good_cnt, 32'd3);
        chk("fill_full_cnt", full_cnt, 32'd0);
        chk("fill_head_tdata", m_axis_tdata, 64'h300);
        m_axis_tready = 1'b1;
        wait_drain("fill_drain", 60);

        // Backpressure over two back-to-back 10-beat frames
        do_reset();
        fork
            begin
                send_frame(10, 64'h400, 8'h3F, 1'b0, 1'b1);
                send_frame(10, 64'h500, 8'h01, 1'b0, 1'b1);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    m_axis_tready = rdy_pat[i];
                    @(posedge clk156); #1;
                end
                m_axis_tready = 1'b1;
            end
        join
        wait_drain("bp_drain", 60);
        chk("bp_good_cnt", good_cnt, 32'd2);
        chk("bp_full_cnt", full_cnt, 32'd0);

        // Reset during beat 3 of a 6-beat frame; source abandons the frame
        do_reset();
        m_axis_tready = 1'b1;
        drive_beat(64'h601, 8'hFF, 1'b0, 1'b0);
        drive_beat(64'h602, 8'hFF, 1'b0, 1'b0);
        eth_rst = 1'b1;
        drive_beat(64'h603, 8'hFF, 1'b0, 1'b0);
        eth_rst = 1'b0;
        idle_in();
        chk("midrst_tvalid", m_axis_tvalid, 1'b0);
        chk("midrst_cnts", {good_cnt, err_cnt, full_cnt}, 96'h0);
        repeat (3) begin @(posedge clk156); #1; end
        chk("midrst_tvalid_later", m_axis_tvalid, 1'b0);
        send_frame(4, 64'h700, 8'h0F, 1'b0, 1'b1);
        wait_drain("midrst_drain", 50);
        chk("midrst_good_cnt", good_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
